// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, state type and sizing helper for bin_to_bcd_hex
package bcd_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low patterns, bit order g..a, indexed by decimal digit.
   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   typedef enum logic {IDLE, SHIFT} state_e;

   // Decimal digits needed to show 2^width - 1.
   function automatic int min_digits(input int width);
      longint unsigned v;
      int d;
      v = (64'd1 << width) - 64'd1;
      d = 0;
      do begin
         d++;
         v = v / 10;
      end while (v != 0);
      return d;
   endfunction

endpackage

// File: rtl/bin_to_bcd_hex_if.sv
// rtl/bin_to_bcd_hex_if.sv - request/result bundle between a value source and the display driver
interface bin_to_bcd_hex_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [WIDTH-1:0]      bin_in;
   logic                  blank_lz;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic [7*DIGITS-1:0]   HEX;

   modport master (
      output start, bin_in, blank_lz,
      input  busy, done, bcd_out, HEX
   );

   modport slave (
      input  start, bin_in, blank_lz,
      output busy, done, bcd_out, HEX
   );
endinterface

// File: rtl/seg7_bcd_dec.sv
// rtl/seg7_bcd_dec.sv - one BCD digit to active-low seven-segment pattern
module seg7_bcd_dec
   import bcd_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank && bcd <= 4'd9) begin
         seg = SEG_DIGIT[bcd];
      end
   end

endmodule

// File: rtl/bin_to_bcd_hex.sv
// rtl/bin_to_bcd_hex.sv - sequential double-dabble converter driving active-low HEX displays
module bin_to_bcd_hex
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic          Clock,
   input  logic          Resetn,
   bin_to_bcd_hex_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("bin_to_bcd_hex: WIDTH must be 1..32");
   end
   if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
      $error("bin_to_bcd_hex: DIGITS too small for WIDTH");
   end

   state_e                state_q, state_d;
   logic [WIDTH-1:0]      shift_q, shift_d;
   logic [4*DIGITS-1:0]   scratch_q, scratch_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic                  done_q, done_d;
   logic [4*DIGITS-1:0]   adj;
   logic [DIGITS:0]       zero_above;
   logic [7*DIGITS-1:0]   hex_w;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      done_d    = 1'b0;

      adj = scratch_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (adj[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
         end
      end

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shift_d   = bus.bin_in;
               scratch_d = '0;
               cnt_d     = CW'(WIDTH);
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            {scratch_d, shift_d} = {adj, shift_q} << 1;
            cnt_d = cnt_q - CW'(1);
            // Last bit consumed: publish the result in the same edge that leaves SHIFT.
            if (cnt_q == CW'(1)) begin
               bcd_d   = scratch_d;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy    = (state_q == SHIFT);
   assign bus.done    = done_q;
   assign bus.bcd_out = bcd_q;

   // zero_above[k]: digits k..DIGITS-1 are all zero.
   always_comb begin
      zero_above = '0;
      zero_above[DIGITS] = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_above[k] = zero_above[k+1] && (bcd_q[4*k +: 4] == 4'd0);
      end
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_dec
      seg7_bcd_dec u_dec (
         .bcd   (bcd_q[4*k +: 4]),
         .blank ((k != 0) && bus.blank_lz && zero_above[k]),
         .seg   (hex_w[7*k +: 7])
      );
   end

   assign bus.HEX = hex_w;

endmodule

// File: tb/tb_bin_to_bcd_hex.sv
// tb/tb_bin_to_bcd_hex.sv - randomized self-checking bench for bin_to_bcd_hex (8x3 and 4x2 configs)
module tb_bin_to_bcd_hex;

   logic Clock  = 1'b0;
   logic Resetn = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 Clock = ~Clock;

   bin_to_bcd_hex_if #(.WIDTH(8), .DIGITS(3)) b8 ();
   bin_to_bcd_hex_if #(.WIDTH(4), .DIGITS(2)) b4 ();

   bin_to_bcd_hex #(.WIDTH(8), .DIGITS(3)) u8 (.Clock(Clock), .Resetn(Resetn), .bus(b8.slave));
   bin_to_bcd_hex #(.WIDTH(4), .DIGITS(2)) u4 (.Clock(Clock), .Resetn(Resetn), .bus(b4.slave));

   logic [6:0] segs [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic logic [63:0] ref_bcd(input int value, input int digits);
      logic [63:0] r = '0;
      int v = value;
      for (int k = 0; k < digits; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [63:0] ref_hex(input int value, input int digits, input bit blz);
      logic [63:0] r = '0;
      int p = 1;
      for (int k = 0; k < digits; k++) begin
         if (k > 0 && blz && value < p) r[7*k +: 7] = 7'h7F;
         else                           r[7*k +: 7] = segs[(value / p) % 10];
         p = p * 10;
      end
      return r;
   endfunction

   task automatic convert(input bit w4, input int value, input bit blz, input string tag);
      int width  = w4 ? 4 : 8;
      int digits = w4 ? 2 : 3;
      int lat = 0;
      if (w4) begin b4.bin_in = 4'(value); b4.blank_lz = blz; b4.start = 1'b1; end
      else    begin b8.bin_in = 8'(value); b8.blank_lz = blz; b8.start = 1'b1; end
      tick();
      b4.start = 1'b0;
      b8.start = 1'b0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         tick();
         if (w4 ? b4.done : b8.done) lat = i;
      end
      check($sformatf("%s latency v=%0d", tag, value), 64'(lat), 64'(width));
      check($sformatf("%s bcd v=%0d", tag, value),
            w4 ? 64'(b4.bcd_out) : 64'(b8.bcd_out), ref_bcd(value, digits));
      check($sformatf("%s hex v=%0d blz=%0d", tag, value, blz),
            w4 ? 64'(b4.HEX) : 64'(b8.HEX), ref_hex(value, digits, blz));
   endtask

   initial begin
      int lat;
      int dones;
      int off;
      b8.start = 1'b0; b8.bin_in = '0; b8.blank_lz = 1'b1;
      b4.start = 1'b0; b4.bin_in = '0; b4.blank_lz = 1'b1;
      repeat (2) tick();

      check("rst bcd", 64'(b8.bcd_out), 64'h000);
      check("rst busy", 64'(b8.busy), 64'd0);
      check("rst done", 64'(b8.done), 64'd0);
      check("rst hex blz1", 64'(b8.HEX), {43'd0, 7'b1111111, 7'b1111111, 7'b1000000});
      check("rst hex4 blz1", 64'(b4.HEX), {50'd0, 7'b1111111, 7'b1000000});
      b8.blank_lz = 1'b0;
      #1;
      check("rst hex blz0", 64'(b8.HEX), {43'd0, 7'b1000000, 7'b1000000, 7'b1000000});

      Resetn = 1'b1;
      tick();

      convert(0, 255, 0, "v255");
      check("v255 hex const", 64'(b8.HEX), {43'd0, 7'b0100100, 7'b0010010, 7'b0010010});
      convert(0, 7, 1, "v7");
      check("v7 hex const", 64'(b8.HEX), {43'd0, 7'b1111111, 7'b1111111, 7'b1111000});
      convert(0, 100, 1, "v100");
      check("v100 embedded zero", 64'(b8.HEX[13:7]), 64'(7'b1000000));

      // Held start with bin_in changing mid-conversion.
      b8.blank_lz = 1'b0;
      b8.bin_in = 8'd200;
      b8.start = 1'b1;
      tick();
      b8.bin_in = 8'd99;
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         tick();
         if (b8.done) lat = i;
      end
      check("held first latency", 64'(lat), 64'd8);
      check("held first bcd", 64'(b8.bcd_out), 64'h200);
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         tick();
         if (b8.done) lat = i;
      end
      b8.start = 1'b0;
      check("held second spacing", 64'(lat), 64'd9);
      check("held second bcd", 64'(b8.bcd_out), 64'h099);
      tick();
      check("held no extra start", 64'(b8.busy), 64'd0);

      // Asynchronous reset in the middle of a conversion.
      b8.bin_in = 8'd123;
      b8.start = 1'b1;
      tick();
      b8.start = 1'b0;
      repeat (3) tick();
      check("pre-abort busy", 64'(b8.busy), 64'd1);
      #2 Resetn = 1'b0;
      #1;
      check("abort busy", 64'(b8.busy), 64'd0);
      check("abort done", 64'(b8.done), 64'd0);
      check("abort bcd", 64'(b8.bcd_out), 64'h000);
      repeat (3) tick();
      Resetn = 1'b1;
      dones = 0;
      repeat (12) begin
         tick();
         if (b8.done) dones++;
      end
      check("abort no done", 64'(dones), 64'd0);
      convert(0, 123, 0, "after abort");

      for (int v = 0; v < 16; v++) convert(1, v, 1'($urandom_range(0, 1)), "exh4");
      check("v15 hex1", 64'(b4.HEX[13:7]), 64'(7'b1111001));

      off = int'($urandom_range(0, 255));
      for (int i = 0; i < 256; i++) begin
         convert(0, (i * 97 + off) % 256, 1'($urandom_range(0, 1)), "all8");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
